// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer for the register-file memory (optional MEM_ARB_ROUNDROBIN_EN)
module mem_arbiter #(
    parameter int DEPTH = 6,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    logic          owner, owner_nx;
    logic          lat_we, lat_we_nx;
    logic          in_rng, in_rng_nx;
    logic [1:0]    gnt_q, gnt_nx;
    logic [1:0]    rvalid_q, rvalid_nx;
    logic [1:0]    err_q, err_nx;
    logic [DW-1:0] rdata0_nx, rdata1_nx;
    logic          cs_nx, we_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] din_nx;
    logic [DW-1:0] resp_data;

    logic          win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_in_rng;

`ifdef MEM_ARB_ROUNDROBIN_EN
    logic rr_ptr, rr_ptr_nx;
`endif

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];

    // Winner selection: a lone requester always wins; only ties consult the policy.
    always_comb begin
`ifdef MEM_ARB_ROUNDROBIN_EN
        if (p0_req && p1_req) win = rr_ptr;
        else                  win = p1_req;
`else
        win = ~p0_req;
`endif
        sel_we     = win ? p1_we    : p0_we;
        sel_addr   = win ? p1_addr  : p0_addr;
        sel_wdata  = win ? p1_wdata : p0_wdata;
        sel_in_rng = ({1'b0, sel_addr} < DEPTH_W);
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        lat_we_nx = lat_we;
        in_rng_nx = in_rng;
        gnt_nx    = 2'b00;
        rvalid_nx = 2'b00;
        err_nx    = 2'b00;
        rdata0_nx = p0_rdata;
        rdata1_nx = p1_rdata;
        cs_nx     = 1'b0;
        we_nx     = 1'b0;
        addr_nx   = mem_addr;
        din_nx    = mem_din;
        resp_data = in_rng ? mem_dout : '0;
`ifdef MEM_ARB_ROUNDROBIN_EN
        rr_ptr_nx = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    owner_nx    = win;
                    lat_we_nx   = sel_we;
                    in_rng_nx   = sel_in_rng;
                    addr_nx     = sel_addr;
                    din_nx      = sel_wdata;
                    gnt_nx[win] = 1'b1;
                    cs_nx       = sel_in_rng;
                    we_nx       = sel_in_rng & sel_we;
                    state_nx    = ACCESS;
`ifdef MEM_ARB_ROUNDROBIN_EN
                    rr_ptr_nx   = ~win;
`endif
                end
            end
            ACCESS: begin
                state_nx = RESP;
                // Reads and rejected accesses both answer; good writes stay silent.
                if (!lat_we || !in_rng) begin
                    rvalid_nx[owner] = 1'b1;
                    err_nx[owner]    = ~in_rng;
                    if (owner) rdata1_nx = resp_data;
                    else       rdata0_nx = resp_data;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            lat_we   <= 1'b0;
            in_rng   <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            p0_rdata <= '0;
            p1_rdata <= '0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
`ifdef MEM_ARB_ROUNDROBIN_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            lat_we   <= lat_we_nx;
            in_rng   <= in_rng_nx;
            gnt_q    <= gnt_nx;
            rvalid_q <= rvalid_nx;
            err_q    <= err_nx;
            p0_rdata <= rdata0_nx;
            p1_rdata <= rdata1_nx;
            mem_cs   <= cs_nx;
            mem_we   <= we_nx;
            mem_addr <= addr_nx;
            mem_din  <= din_nx;
`ifdef MEM_ARB_ROUNDROBIN_EN
            rr_ptr   <= rr_ptr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [2:0]  p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_cs, mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_din, mem_dout;

    logic [15:0] mem     [0:7];
    logic [15:0] ref_mem [0:7];
    logic [15:0] snap    [0:7];

    int vectors     = 0;
    int miscompares = 0;

    logic        stab_en = 1'b0;
    logic [2:0]  stab_addr;
    logic [15:0] stab_din;
    logic        stab_we;

    logic [15:0] rd;
    logic [3:0]  exp_owner;
    int          ng;

    mem_arbiter #(.DEPTH(6), .AW(3), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Register-file memory: asynchronous read, write on the edge closing ACCESS.
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h0;
        end else if (mem_cs && mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {5'b0, p0_gnt, p0_rvalid, p0_rdata, p0_err,
                p1_gnt, p1_rvalid, p1_rdata, p1_err,
                mem_cs, mem_we, mem_addr, mem_din};
    endfunction

    // Starts and ends at a negedge with the arbiter idle.
    task automatic xfer(input bit port, input bit we, input logic [2:0] addr,
                        input logic [15:0] wd, output logic [15:0] rdo);
        int          c;
        bit          inr;
        logic [15:0] exp;
        inr = (addr < 3'd6);
        exp = inr ? ref_mem[addr] : 16'h0;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(port ? p1_gnt : p0_gnt) && c < 10);
        chk("gnt_latency", c, 1);
        chk("other_gnt", port ? p0_gnt : p1_gnt, 0);
        chk("access_cs", mem_cs, inr);
        chk("access_we", mem_we, inr & we);
        if (inr) chk("access_addr", mem_addr, addr);
        if (inr && we) chk("access_din", mem_din, wd);
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        chk("resp_cs", {mem_cs, mem_we}, 0);
        chk("resp_gnt", {p0_gnt, p1_gnt}, 0);
        chk("resp_rvalid", port ? p1_rvalid : p0_rvalid, (!we || !inr));
        chk("resp_other_rvalid", port ? p0_rvalid : p1_rvalid, 0);
        chk("resp_err", port ? p1_err : p0_err, !inr);
        rdo = port ? p1_rdata : p0_rdata;
        if (!we || !inr) chk("resp_rdata", rdo, exp);
        if (we && inr) ref_mem[addr] = wd;
        @(negedge clk);
        chk("idle_rvalid_err", {p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
    endtask

    // Memory-side signals must hold across the whole ACCESS cycle.
    always begin
        @(posedge clk);
        #1;
        if (stab_en && (p0_gnt || p1_gnt)) begin
            stab_addr = mem_addr;
            stab_din  = mem_din;
            stab_we   = mem_we;
            #7;
            chk("access_stable", {mem_addr, mem_din, mem_we}, {stab_addr, stab_din, stab_we});
        end
    end

    initial begin
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", all_outs(), 0);

        xfer(0, 1, 3'd2, 16'hA5C3, rd);
        xfer(0, 0, 3'd2, 16'h0000, rd);
        chk("wr_rd_a5c3", rd, 16'hA5C3);

        xfer(1, 1, 3'd6, 16'hFFFF, rd);
        chk("oor_rdata", rd, 16'h0);
        chk("oor_row6_untouched", mem[6], 16'h0);
        for (int a = 0; a < 6; a++) begin
            xfer(0, 0, 3'(a), 16'h0, rd);
            if (a == 2) chk("oor_row2_kept", rd, 16'hA5C3);
        end
        xfer(1, 0, 3'd7, 16'h0, rd);
        chk("oor_read_rdata", rd, 16'h0);

        xfer(0, 1, 3'd1, 16'h1111, rd);
        xfer(1, 1, 3'd3, 16'h3333, rd);

`ifdef MEM_ARB_ROUNDROBIN_EN
        exp_owner = 4'b1010;
`else
        exp_owner = 4'b0000;
`endif
        p0_req = 1; p0_we = 0; p0_addr = 3'd1;
        p1_req = 1; p1_we = 0; p1_addr = 3'd3;
        ng = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("cont_onehot", p0_gnt & p1_gnt, 0);
            if (p0_gnt || p1_gnt) begin
                chk("cont_gnt_cycle", k % 3, 1);
                if (ng < 4) chk("cont_owner", p1_gnt, exp_owner[ng]);
                ng++;
            end
            if (p0_rvalid) chk("cont_p0_rdata", p0_rdata, 16'h1111);
            if (p1_rvalid) chk("cont_p1_rdata", p1_rdata, 16'h3333);
        end
        chk("cont_ngrants", ng, 4);
        p0_req = 0;
        p1_req = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) snap[i] = mem[i];
        xfer(1, 1, 3'd5, 16'h1234, rd);
        xfer(0, 0, 3'd5, 16'h0, rd);
        chk("iso_rdata", rd, 16'h1234);
        for (int r = 0; r < 8; r++) begin
            if (r != 5) chk("iso_row_unchanged", mem[r], snap[r]);
        end

        p0_req = 1; p0_we = 0; p0_addr = 3'd2;
        @(negedge clk);
        chk("rma_gnt", p0_gnt, 1);
        rst = 1'b1;
        p0_req = 0;
        @(negedge clk);
        chk("rma_outputs", all_outs(), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rma_no_rvalid", {p0_rvalid, p0_gnt}, 0);
        end
        for (int a = 0; a < 6; a++) begin
            xfer(a[0], 0, 3'(a), 16'h0, rd);
            chk("rma_mem_zero", rd, 16'h0);
        end

        stab_en = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 16'($urandom), rd);
        end
        stab_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 16-bit register-file memory (cs/we/addr/din/dout interface, DEPTH implemented rows).
- Shares the memory between port 0 (CPU core) and port 1 (loader/debug).
- Performs one access per grant through a fixed three-state sequence, so mem_cs/mem_we/mem_addr/mem_din are stable for a full clock period.
- Rejects addresses beyond the implemented rows with an error response.

Parameters:
- DEPTH, 6: number of implemented memory rows; addresses >= DEPTH are out of range.
- AW, 3: address width.
- DW, 16: data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request; level, held until p0_gnt seen.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 granted; high for exactly the ACCESS cycle.
- p0_rvalid  out  1  port 0 response strobe; one cycle, for reads and errored accesses.
- p0_rdata  out  DW  port 0 read data; valid with p0_rvalid.
- p0_err  out  1  port 0 out-of-range flag; valid with p0_rvalid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_dout  in  DW  memory read data.

Behaviour:
- All outputs are registered. On rst, all outputs are 0, state goes to IDLE, and the round-robin pointer points at port 0. Reset mid-access abandons the access, with no gnt or rvalid afterwards.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high at the clock edge, choose the winner (fixed priority or round-robin, see Optional Feature).
  - Latch the owner, we, addr and wdata, then go to ACCESS.
  - If no req is high, stay in IDLE with mem_cs = 0.
- ACCESS (exactly 1 cycle):
  - The owner's gnt is 1; the other port's gnt is 0.
  - In range (addr < DEPTH): mem_cs = 1, mem_we = latched we, mem_addr = latched addr, mem_din = latched wdata, all stable for the whole cycle. A write commits to memory during this cycle.
  - Out of range: mem_cs = 0 and mem_we = 0, so the memory is untouched.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - mem_cs = 0, mem_we = 0; mem_addr and mem_din hold their values.
  - In-range read: owner rdata = mem_dout sampled at the ACCESS→RESP edge; rvalid = 1; err = 0.
  - In-range write: no rvalid.
  - Out of range (read or write): rvalid = 1, err = 1, rdata = 0.
  - Next state is IDLE.
- Latency:
  - A request sampled high in IDLE at edge N gives gnt in cycle N+1 and rvalid in cycle N+2.
  - Minimum spacing between accesses is 3 cycles.
  - The cs-low RESP cycle guarantees no back-to-back gated write clock pulses.
- Requesters must hold req, we, addr and wdata stable until they see gnt. A req still high after gnt is treated as a new request at the next IDLE sample.
- When both ports request in the same cycle, exactly one is granted. The loser's req stays pending and is granted at the next IDLE if it is still high.
- rdata holds its last value while rvalid = 0. err is 0 whenever rvalid = 0.

Optional Feature:
- MEM_ARB_ROUNDROBIN_EN defined:
  - Round-robin arbitration. After each grant, the pointer moves to the other port.
  - On a simultaneous request, the port the pointer selects wins.
  - A single requester is always granted regardless of the pointer.
- MEM_ARB_ROUNDROBIN_EN undefined: fixed priority, port 0 always wins a simultaneous request, and the pointer logic is absent.

Test Plan:
- Reset then write/read: p0 writes addr 2 = 16'hA5C3, then p0 reads addr 2 → p0_rvalid after 2 cycles with p0_rdata = 16'hA5C3, p0_err = 0; mem_cs high exactly 1 cycle per access.
- Out-of-range: p1 writes addr 6 data 16'hFFFF → mem_cs stays 0, p1_rvalid = 1 with p1_err = 1 and p1_rdata = 0; a later read of addr 0..5 returns the prior contents, unchanged.
- Contention: p0 and p1 both request continuously (reads of addr 1 and addr 3):
  - Without the macro: only p0 is granted, every 3 cycles.
  - With MEM_ARB_ROUNDROBIN_EN: grants alternate p0, p1, p0, p1.
- Write isolation: p1 writes addr 5 = 16'h1234 while p0 reads addr 5 in the next grant → p0_rdata = 16'h1234, and no row other than 5 changes.
- Reset mid-access: assert rst during ACCESS of a p0 read → next cycle all outputs 0, no p0_rvalid; the memory reads 16'h0000 at all addresses afterwards.
- Stability check: during every ACCESS cycle, mem_addr, mem_din and mem_we do not toggle, checked by an assertion over random traffic of 2000 requests.
